// File: rtl/decode_pkg.sv
// Shared widths, packed bundle layout and field helpers for the decode interchange link.
package decode_pkg;
  localparam int FMT_W      = 4;
  localparam int OPCODE_W   = 12;
  localparam int ADDR_W     = 64;
  localparam int FU_W       = 3;
  localparam int MAJ_W      = 64;
  localparam int MIN_W      = 7;
  localparam int PID_W      = 32;
  localparam int TID_W      = 64;
  localparam int RAP_W      = 2;
  localparam int BODY_W     = 32;
  localparam int NUM_OPS    = 4;
  localparam int NUM_LANES  = 4;
  localparam int FIFO_DEPTH = 8;

  // Field offsets, LSB first; these match the member order of bundle_s below
  localparam int FMT_LSB   = 0;
  localparam int OPC_LSB   = FMT_LSB + FMT_W;
  localparam int ADDR_LSB  = OPC_LSB + OPCODE_W;
  localparam int FU_LSB    = ADDR_LSB + ADDR_W;
  localparam int MAJ_LSB   = FU_LSB + FU_W;
  localparam int MIN_LSB   = MAJ_LSB + MAJ_W;
  localparam int IS64_LSB  = MIN_LSB + MIN_W;
  localparam int PID_LSB   = IS64_LSB + 1;
  localparam int TID_LSB   = PID_LSB + PID_W;
  localparam int RW_LSB    = TID_LSB + TID_W;
  localparam int ISREG_LSB = RW_LSB + NUM_OPS * RAP_W;
  localparam int BODY_LSB  = ISREG_LSB + NUM_OPS;
  localparam int BUNDLE_W  = BODY_LSB + BODY_W;

  typedef logic [BUNDLE_W-1:0] bundle_t;

  typedef struct packed {
    logic [BODY_W-1:0]             body;
    logic [NUM_OPS-1:0]            op_is_reg;
    logic [NUM_OPS-1:0][RAP_W-1:0] op_rw;
    logic [TID_W-1:0]              tid;
    logic [PID_W-1:0]              pid;
    logic                          is64;
    logic [MIN_W-1:0]              min_id;
    logic [MAJ_W-1:0]              maj_id;
    logic [FU_W-1:0]               func_unit;
    logic [ADDR_W-1:0]             address;
    logic [OPCODE_W-1:0]           opcode;
    logic [FMT_W-1:0]              format;
  } bundle_s;

  function automatic logic [TID_W-1:0] bundle_tid(bundle_t b);
    return b[TID_LSB +: TID_W];
  endfunction

  function automatic logic [MAJ_W-1:0] bundle_maj(bundle_t b);
    return b[MAJ_LSB +: MAJ_W];
  endfunction
endpackage

// File: rtl/decode_lane_packer_if.sv
// Decoder-side handshake plus the 4-lane group output of the packer.
interface decode_lane_packer_if #(parameter int FifoDepth = 8);
  import decode_pkg::*;
  logic                            flush;
  logic                            valid;
  logic                            ready;
  bundle_t                         bundle;
  logic                            stall;
  logic [NUM_LANES-1:0]            enable;
  bundle_t [NUM_LANES-1:0]         lane;
  logic [$clog2(FifoDepth):0]      occupancy;

  modport master (output flush, valid, bundle, stall,
                  input  ready, enable, lane, occupancy);
  modport slave  (input  flush, valid, bundle, stall,
                  output ready, enable, lane, occupancy);
endinterface

// File: rtl/decode_bundle_fifo.sv
// In-order bundle buffer: one write port, NUM_LANES read ports at head+0..3, multi-pop.
module decode_bundle_fifo
  import decode_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int PW    = $clog2(DEPTH),
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic                    clock_i,
  input  logic                    reset_i,
  input  logic                    flush,
  input  logic                    push,
  input  bundle_t                 wdata,
  input  logic [2:0]              pop_cnt,
  output bundle_t [NUM_LANES-1:0] rdata,
  output logic [CW-1:0]           count,
  output logic                    full
);
  bundle_t         mem [DEPTH];
  logic [PW-1:0]   head, tail;

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= tail;
      count <= '0;
    end else begin
      if (push) tail <= tail + PW'(1);
      head  <= head + PW'(pop_cnt);
      count <= count + CW'(push) - CW'(pop_cnt);
    end
  end

  always_ff @(posedge clock_i) begin
    if (push && !flush) mem[tail] <= wdata;
  end

  // Read addresses wrap naturally in PW bits, so a group may straddle the end of mem
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_rd
    assign rdata[i] = mem[head + PW'(i)];
  end

  assign full = (count == CW'(DEPTH));
endmodule

// File: rtl/decode_lane_packer.sv
// Packs buffered decode bundles into same-thread groups of up to four lanes per cycle.
module decode_lane_packer
  import decode_pkg::*;
#(
  parameter int FifoDepth = FIFO_DEPTH
) (
  input  logic                 clock_i,
  input  logic                 reset_i,
  decode_lane_packer_if.slave  lnk
);
  localparam int CW = $clog2(FifoDepth) + 1;

  bundle_t [NUM_LANES-1:0] rd;
  logic [CW-1:0]           count;
  logic                    full;
  logic                    push;
  logic [2:0]              grp_n;
  logic [2:0]              pop_cnt;
  logic                    brk;
  logic [NUM_LANES-1:0]    en_q;
  bundle_t [NUM_LANES-1:0] lane_q;

  assign push = lnk.valid & ~full & ~lnk.flush;

  decode_bundle_fifo #(.DEPTH(FifoDepth)) u_fifo (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .flush   (lnk.flush),
    .push    (push),
    .wdata   (lnk.bundle),
    .pop_cnt (pop_cnt),
    .rdata   (rd),
    .count   (count),
    .full    (full)
  );

  // Group = leading run of buffered entries sharing the head's thread, capped at 4
  always_comb begin
    grp_n = '0;
    brk   = 1'b0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (!brk && (CW'(i) < count) &&
          (i == 0 || bundle_tid(rd[i]) == bundle_tid(rd[0])))
        grp_n = 3'(i + 1);
      else
        brk = 1'b1;
    end
  end

  assign pop_cnt = (lnk.stall | lnk.flush) ? 3'd0 : grp_n;

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      en_q   <= '0;
      lane_q <= '0;
    end else if (lnk.flush) begin
      en_q   <= '0;
    end else if (!lnk.stall) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        en_q[i]   <= (3'(i) < grp_n);
        lane_q[i] <= rd[i];
      end
    end
  end

  assign lnk.ready     = ~full;
  assign lnk.occupancy = count;
  assign lnk.enable    = en_q;
  assign lnk.lane      = lane_q;
endmodule

// File: tb/tb_decode_lane_packer.sv
// Directed and randomized checks of decode_lane_packer against a queue-based model.
module tb_decode_lane_packer;
  import decode_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  decode_lane_packer_if #(.FifoDepth(8)) lnk();
  decode_lane_packer #(.FifoDepth(8)) dut (.clock_i(clk), .reset_i(rst_n), .lnk(lnk));

  int err = 0;
  int chk = 0;

  task automatic check(string name, logic [BUNDLE_W-1:0] act, logic [BUNDLE_W-1:0] exp);
    chk++;
    if (act !== exp) begin
      err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: a plain queue; each edge forms the group from the pre-edge contents
  bundle_t      mq[$];
  logic [3:0]   m_en;
  bundle_t      m_lane[4];
  bit           m_new;

  always @(posedge clk or negedge rst_n) begin : model
    int n;
    bit pok;
    if (!rst_n) begin
      mq.delete();
      m_en  = '0;
      m_new = 0;
      for (int i = 0; i < 4; i++) m_lane[i] = '0;
    end else begin
      m_new = 0;
      if (lnk.flush) begin
        mq.delete();
        m_en = '0;
      end else begin
        pok = lnk.valid && (mq.size() < 8);
        n = (mq.size() > 4) ? 4 : mq.size();
        for (int i = 1; i < n; i++)
          if (bundle_tid(mq[i]) != bundle_tid(mq[0])) begin n = i; break; end
        if (!lnk.stall) begin
          m_en = '0;
          for (int i = 0; i < n; i++) begin
            m_en[i]   = 1'b1;
            m_lane[i] = mq[i];
          end
          repeat (n) void'(mq.pop_front());
          m_new = (n > 0);
        end
        if (pok) mq.push_back(lnk.bundle);
      end
    end
  end

  logic [3:0]        log_mask[$];
  logic [MAJ_W-1:0]  log_ids[$];

  always @(negedge clk) begin
    if (rst_n) begin
      check("ready", BUNDLE_W'(lnk.ready), BUNDLE_W'(mq.size() != 8));
      check("occupancy", BUNDLE_W'(lnk.occupancy), BUNDLE_W'(mq.size()));
      check("enable", BUNDLE_W'(lnk.enable), BUNDLE_W'(m_en));
      for (int i = 0; i < 4; i++)
        if (m_en[i]) check($sformatf("lane%0d", i + 1), lnk.lane[i], m_lane[i]);
      if (m_new) begin
        log_mask.push_back(lnk.enable);
        for (int i = 0; i < 4; i++)
          if (lnk.enable[i]) log_ids.push_back(bundle_maj(lnk.lane[i]));
      end
    end
  end

  localparam logic [63:0] TID_A = 64'h0000_0000_AAAA_0001;
  localparam logic [63:0] TID_B = 64'h0000_0000_BBBB_0002;

  function automatic bundle_t mk(int id, logic [63:0] tid);
    bundle_t b;
    bundle_s s;
    for (int i = 0; i < BUNDLE_W; i++) b[i] = 1'($urandom);
    s = b;
    s.maj_id = MAJ_W'(id);
    s.tid    = tid;
    return s;
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic push_stalled(int first, int n, logic [63:0] tid);
    lnk.stall = 1'b1;
    for (int i = 0; i < n; i++) begin
      lnk.valid  = 1'b1;
      lnk.bundle = mk(first + i, tid);
      tick();
    end
    lnk.valid = 1'b0;
  endtask

  task automatic drain();
    lnk.stall = 1'b0;
    lnk.valid = 1'b0;
    for (int c = 0; c < 60 && lnk.occupancy != 0; c++) tick();
    check("drain_done", BUNDLE_W'(lnk.occupancy), '0);
  endtask

  task automatic check_log(string name, logic [3:0] m0, logic [3:0] m1, int first, int nid);
    check({name, "_groups"}, BUNDLE_W'(log_mask.size()), BUNDLE_W'(2));
    check({name, "_ids"}, BUNDLE_W'(log_ids.size()), BUNDLE_W'(nid));
    if (log_mask.size() == 2) begin
      check({name, "_mask0"}, BUNDLE_W'(log_mask[0]), BUNDLE_W'(m0));
      check({name, "_mask1"}, BUNDLE_W'(log_mask[1]), BUNDLE_W'(m1));
    end
    for (int i = 0; i < nid && i < log_ids.size(); i++)
      check($sformatf("%s_id%0d", name, i), BUNDLE_W'(log_ids[i]), BUNDLE_W'(first + i));
  endtask

  logic [63:0] rtid [200];

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx, cyc;
    bit acc, is_th;
    lnk.flush = 1'b0; lnk.stall = 1'b0; lnk.valid = 1'b1;
    lnk.bundle = mk(100, TID_A);

    // 1: reset held with valid asserted
    repeat (3) begin
      @(negedge clk); #1;
      check("rst_enable", BUNDLE_W'(lnk.enable), '0);
      check("rst_occ", BUNDLE_W'(lnk.occupancy), '0);
      check("rst_ready", BUNDLE_W'(lnk.ready), BUNDLE_W'(1));
      check("rst_lane1", lnk.lane[0], '0);
    end
    rst_n = 1'b1;
    #1 check("post_rst_occ", BUNDLE_W'(lnk.occupancy), '0);
    tick();
    check("first_push_occ", BUNDLE_W'(lnk.occupancy), BUNDLE_W'(1));
    check("first_push_en", BUNDLE_W'(lnk.enable), '0);
    lnk.valid = 1'b0;
    tick();
    check("first_emit_en", BUNDLE_W'(lnk.enable), BUNDLE_W'(4'b0001));
    check("first_emit_id", BUNDLE_W'(bundle_maj(lnk.lane[0])), BUNDLE_W'(100));

    // 2: six same-thread bundles
    push_stalled(0, 6, TID_A);
    check("t2_occ", BUNDLE_W'(lnk.occupancy), BUNDLE_W'(6));
    log_mask.delete(); log_ids.delete();
    drain();
    check_log("t2", 4'b1111, 4'b0011, 0, 6);

    // 3: fill to capacity under stall
    lnk.stall = 1'b1;
    for (int i = 0; i < 9; i++) begin
      lnk.valid = 1'b1; lnk.bundle = mk(i, TID_A);
      tick();
      if (i == 7) check("t3_full_ready", BUNDLE_W'(lnk.ready), '0);
    end
    lnk.valid = 1'b0;
    check("t3_occ", BUNDLE_W'(lnk.occupancy), BUNDLE_W'(8));
    log_mask.delete(); log_ids.delete();
    drain();
    check_log("t3", 4'b1111, 4'b1111, 0, 8);

    // 4: thread break A,A,B,B,B
    push_stalled(10, 2, TID_A);
    push_stalled(12, 3, TID_B);
    log_mask.delete(); log_ids.delete();
    drain();
    check_log("t4", 4'b0011, 4'b0111, 10, 5);

    // 5: flush with a concurrent push
    push_stalled(20, 5, TID_A);
    log_mask.delete(); log_ids.delete();
    lnk.flush = 1'b1; lnk.valid = 1'b1; lnk.stall = 1'b0; lnk.bundle = mk(99, TID_A);
    tick();
    lnk.flush = 1'b0; lnk.valid = 1'b0;
    check("t5_en", BUNDLE_W'(lnk.enable), '0);
    check("t5_occ", BUNDLE_W'(lnk.occupancy), '0);
    repeat (3) tick();
    check("t5_no_emit", BUNDLE_W'(log_ids.size()), '0);

    // 7: asynchronous reset in the middle of traffic
    push_stalled(30, 3, TID_B);
    lnk.stall = 1'b0;
    tick();
    check("t7_emit", BUNDLE_W'(lnk.enable), BUNDLE_W'(4'b0111));
    push_stalled(33, 2, TID_B);
    #2 rst_n = 1'b0;
    #1;
    check("t7_rst_en", BUNDLE_W'(lnk.enable), '0);
    check("t7_rst_occ", BUNDLE_W'(lnk.occupancy), '0);
    check("t7_rst_ready", BUNDLE_W'(lnk.ready), BUNDLE_W'(1));
    @(negedge clk); #1 rst_n = 1'b1;
    tick();

    // 6: random traffic, 200 bundles in order
    rtid[0] = TID_A;
    for (int i = 1; i < 200; i++)
      rtid[i] = ($urandom_range(3) == 0) ? ((rtid[i-1] == TID_A) ? TID_B : TID_A) : rtid[i-1];
    log_mask.delete(); log_ids.delete();
    idx = 0; cyc = 0;
    while (idx < 200 && cyc < 5000) begin
      lnk.valid  = ($urandom_range(3) != 0);
      lnk.stall  = ($urandom_range(2) == 0);
      lnk.bundle = mk(idx, rtid[idx]);
      acc = lnk.valid && lnk.ready;
      tick();
      if (acc) idx++;
      cyc++;
    end
    check("t6_all_pushed", BUNDLE_W'(idx), BUNDLE_W'(200));
    drain();
    check("t6_count", BUNDLE_W'(log_ids.size()), BUNDLE_W'(200));
    for (int i = 0; i < log_ids.size() && i < 200; i++)
      check($sformatf("t6_order%0d", i), BUNDLE_W'(log_ids[i]), BUNDLE_W'(i));
    foreach (log_mask[i]) begin
      is_th = (log_mask[i] == 4'b0001) || (log_mask[i] == 4'b0011) ||
              (log_mask[i] == 4'b0111) || (log_mask[i] == 4'b1111);
      check($sformatf("t6_therm%0d", i), BUNDLE_W'(is_th), BUNDLE_W'(1));
    end

    $display("Result: errors=%0d of %0d checks", err, chk);
    $finish;
  end
endmodule
